// File: rtl/game_flow_ctrl.sv
// Screen/game-flow controller: click decoding, stage sequencing and the
// per-stage countdown timer feeding the interface drawing stage.
module game_flow_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int STAGE_TIME    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       click,
  input  logic [8:0] cur_h,
  input  logic [7:0] cur_v,
  input  logic       stage_clear,
  input  logic       stage_fail,
  output logic [3:0] state,
  output logic [1:0] cur_stage,
  output logic [7:0] time_left,
  output logic       stage_start
);

  localparam int            TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    TIME_INIT = 8'(STAGE_TIME);

  // Encoding is shared with the drawing stage and must not change.
  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAFF    = 4'd1,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_STAGE2   = 4'd4,
    ST_SUCCESS2 = 4'd5,
    ST_STAGE3   = 4'd6,
    ST_SUCCESS3 = 4'd7,
    ST_FAIL     = 4'd8
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic          click_d;
  logic          click_evt_reg;
  logic [8:0]    h_reg;
  logic [7:0]    v_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [7:0]    time_left_reg;
  logic [1:0]    cur_stage_reg;
  logic          stage_start_reg;
  logic          enter_stage;
  logic [1:0]    enter_k;
  logic          in_stage;
  logic          hit_col;
  logic          hit_a;
  logic          hit_b;
  logic          hit_c;
  logic          hit_staff;

  assign state       = state_reg;
  assign cur_stage   = cur_stage_reg;
  assign time_left   = time_left_reg;
  assign stage_start = stage_start_reg;

  // Hit tests use the cursor latched together with the click event.
  assign hit_col   = (h_reg >= 9'd120) && (h_reg < 9'd200);
  assign hit_a     = hit_col && (v_reg >= 8'd120) && (v_reg < 8'd140);
  assign hit_b     = hit_col && (v_reg >= 8'd160) && (v_reg < 8'd180);
  assign hit_c     = hit_col && (v_reg >= 8'd200) && (v_reg < 8'd220);
  assign hit_staff = (h_reg >= 9'd280) && (h_reg < 9'd320) && (v_reg >= 8'd220) && (v_reg < 8'd240);

  assign in_stage = (state_reg == ST_STAGE1) || (state_reg == ST_STAGE2) ||
                    (state_reg == ST_STAGE3);

  always_comb begin
    state_next  = state_reg;
    enter_stage = 1'b0;
    enter_k     = cur_stage_reg;
    case (state_reg)
      ST_TITLE: begin
        if (click_evt_reg) begin
          if (hit_a) begin
            state_next = ST_STAGE1; enter_stage = 1'b1; enter_k = 2'd1;
          end else if (hit_b) begin
            state_next = ST_STAGE2; enter_stage = 1'b1; enter_k = 2'd2;
          end else if (hit_c) begin
            state_next = ST_STAGE3; enter_stage = 1'b1; enter_k = 2'd3;
          end else if (hit_staff) begin
            state_next = ST_STAFF;
          end
        end
      end
      ST_STAFF: if (click_evt_reg) state_next = ST_TITLE;
      ST_SUCCESS1: begin
        if (click_evt_reg && hit_b) begin
          state_next = ST_STAGE2; enter_stage = 1'b1; enter_k = 2'd2;
        end else if (click_evt_reg && hit_c) begin
          state_next = ST_TITLE;
        end
      end
      ST_SUCCESS2: begin
        if (click_evt_reg && hit_b) begin
          state_next = ST_STAGE3; enter_stage = 1'b1; enter_k = 2'd3;
        end else if (click_evt_reg && hit_c) begin
          state_next = ST_TITLE;
        end
      end
      ST_SUCCESS3: begin
        if (click_evt_reg && hit_b) state_next = ST_STAFF;
        else if (click_evt_reg && hit_c) state_next = ST_TITLE;
      end
      ST_FAIL: begin
        if (click_evt_reg && hit_b && (cur_stage_reg != 2'd0)) begin
          enter_stage = 1'b1;
          case (cur_stage_reg)
            2'd1:    state_next = ST_STAGE1;
            2'd2:    state_next = ST_STAGE2;
            default: state_next = ST_STAGE3;
          endcase
        end else if (click_evt_reg && hit_c) begin
          state_next = ST_TITLE;
        end
      end
      // Clear is tested first so it wins over a simultaneous fail or timeout.
      ST_STAGE1: begin
        if (stage_clear) state_next = ST_SUCCESS1;
        else if (stage_fail || (time_left_reg == 8'd0)) state_next = ST_FAIL;
      end
      ST_STAGE2: begin
        if (stage_clear) state_next = ST_SUCCESS2;
        else if (stage_fail || (time_left_reg == 8'd0)) state_next = ST_FAIL;
      end
      ST_STAGE3: begin
        if (stage_clear) state_next = ST_SUCCESS3;
        else if (stage_fail || (time_left_reg == 8'd0)) state_next = ST_FAIL;
      end
      default: state_next = ST_TITLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_TITLE;
      click_d         <= 1'b0;
      click_evt_reg   <= 1'b0;
      h_reg           <= '0;
      v_reg           <= '0;
      tick_cnt_reg    <= '0;
      time_left_reg   <= TIME_INIT;
      cur_stage_reg   <= 2'd0;
      stage_start_reg <= 1'b0;
    end else begin
      click_d         <= click;
      click_evt_reg   <= click & ~click_d;
      h_reg           <= cur_h;
      v_reg           <= cur_v;
      state_reg       <= state_next;
      stage_start_reg <= 1'b0;
      if (in_stage) begin
        if (tick_cnt_reg == TICK_MAX) begin
          tick_cnt_reg <= '0;
          if (time_left_reg != 8'd0) time_left_reg <= time_left_reg - 8'd1;
        end else begin
          tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
      end
      // Stage entry overrides the timer update made above.
      if (enter_stage) begin
        cur_stage_reg   <= enter_k;
        time_left_reg   <= TIME_INIT;
        tick_cnt_reg    <= '0;
        stage_start_reg <= 1'b1;
      end
    end
  end

endmodule
